adder_arbiter: RTL and testbench

- Shares the single registered 8-bit `adder` datapath between N_REQ independent requesters.
- Per-requester valid/ready handshake on the request side; fixed-latency, no-backpressure response side.
- Round-robin arbitration issues at most one operation per cycle.
- Tracks in-flight operations with a tag pipeline matched to the adder latency, and routes each result back to the requester that issued it.

---
 rtl/adder_arb_pkg.sv | 49 ++++
 rtl/adder_arbiter_rr_arbiter.sv | 43 ++++
 rtl/adder_arbiter.sv | 161 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter: tag pipeline entries,
// controller states and the round-robin search used by the picker.
package adder_arb_pkg;

    // Type widths are sized for the largest supported requester count (8),
    // so a single tag/index type serves every configuration.
    localparam int N_REQ_MAX = 8;
    localparam int TAG_ID_W  = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                found;
        logic [TAG_ID_W-1:0] idx;
    } pick_t;

    // First requester with its request bit set, searching from ptr upward
    // and wrapping at n. Only the low n bits of req are considered.
    function automatic pick_t rr_pick(input logic [N_REQ_MAX-1:0] req,
                                      input logic [TAG_ID_W-1:0]  ptr,
                                      input int                   n);
        pick_t             r;
        logic [TAG_ID_W:0] j;
        logic [TAG_ID_W:0] nn;
        r  = '0;
        nn = (TAG_ID_W+1)'(n);
        for (int k = 0; k < N_REQ_MAX; k++) begin
            j = {1'b0, ptr} + (TAG_ID_W+1)'(k);
            if (j >= nn) begin
                j = j - nn;
            end
            if ((k < n) && !r.found && req[j[TAG_ID_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[TAG_ID_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin picker: reports the next requester to serve, starting from
// the requester after the last one granted.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [N_REQ-1:0]    i_req,
    input  logic                i_advance,
    output logic                o_found,
    output logic [TAG_ID_W-1:0] o_idx
);

    logic [TAG_ID_W-1:0]  r_ptr;
    logic [N_REQ_MAX-1:0] w_reqExt;
    pick_t                w_pick;

    // Widen the request vector to the helper's fixed width and search it.
    always_comb begin
        w_reqExt            = '0;
        w_reqExt[N_REQ-1:0] = i_req;
        w_pick              = rr_pick(w_reqExt, r_ptr, N_REQ);
    end

    assign o_found = w_pick.found;
    assign o_idx   = w_pick.idx;

    // Move the search start just past the winner whenever a grant is taken.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_advance && w_pick.found) begin
            if (w_pick.idx == TAG_ID_W'(N_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_pick.idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered adder among several requesters. Grants one request
// per cycle in round-robin order, tracks each operation with a tag that
// travels alongside the adder latency, and steers every result back to the
// requester that issued it.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*DATA_W-1:0] req_a_i,
    input  logic [N_REQ*DATA_W-1:0] req_b_i,
    output logic [DATA_W-1:0]       add_a_o,
    output logic [DATA_W-1:0]       add_b_o,
    input  logic [DATA_W-1:0]       add_res_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_res_o,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        issued_cnt_o
);

    state_t              r_state;
    tag_t                r_tags [0:ADD_LAT];
    logic [DATA_W-1:0]   r_addA;
    logic [DATA_W-1:0]   r_addB;
    logic [N_REQ-1:0]    r_rspValid;
    logic [DATA_W-1:0]   r_rspRes;
    logic [CNT_W-1:0]    r_issuedCnt;

    logic                w_grantEn;
    logic                w_found;
    logic                w_hs;
    logic                w_inFlight;
    logic [TAG_ID_W-1:0] w_idx;
    logic [DATA_W-1:0]   w_selA;
    logic [DATA_W-1:0]   w_selB;
    logic [N_REQ-1:0]    w_rspOnehot;

    assign w_grantEn = (r_state == RUN) && enable_i;
    assign w_hs      = w_grantEn && w_found;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rrArbiter (
        .i_clk     (clk_i),
        .i_reset   (reset_i),
        .i_req     (req_valid_i),
        .i_advance (w_hs),
        .o_found   (w_found),
        .o_idx     (w_idx)
    );

    // Decode the winner into its ready bit and operands, and the tag leaving
    // the pipeline into a one-hot response strobe.
    always_comb begin
        req_ready_o = '0;
        w_selA      = '0;
        w_selB      = '0;
        w_rspOnehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == TAG_ID_W'(i)) begin
                req_ready_o[i] = w_hs;
                w_selA         = req_a_i[i*DATA_W +: DATA_W];
                w_selB         = req_b_i[i*DATA_W +: DATA_W];
            end
            if (r_tags[ADD_LAT].id == TAG_ID_W'(i)) begin
                w_rspOnehot[i] = 1'b1;
            end
        end
    end

    // Any live tag anywhere in the pipeline means a result is still owed.
    always_comb begin
        w_inFlight = 1'b0;
        for (int s = 0; s <= ADD_LAT; s++) begin
            w_inFlight = w_inFlight | r_tags[s].valid;
        end
    end

    // Controller: IDLE until there is work, RUN while granting, DRAIN lets
    // in-flight operations finish after enable drops.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable_i && (|req_valid_i)) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable_i) begin
                        r_state <= RUN;
                    end else if (!w_inFlight) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag pipeline: one entry per edge of adder latency plus the operand
    // register stage, shifted every cycle so it lines up with add_res_i.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s <= ADD_LAT; s++) begin
                r_tags[s] <= '0;
            end
        end else begin
            r_tags[0] <= {w_hs, w_idx};
            for (int s = 1; s <= ADD_LAT; s++) begin
                r_tags[s] <= r_tags[s-1];
            end
        end
    end

    // Operand capture, issue counting and response capture.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_addA      <= '0;
            r_addB      <= '0;
            r_issuedCnt <= '0;
            r_rspValid  <= '0;
            r_rspRes    <= '0;
        end else begin
            if (w_hs) begin
                r_addA      <= w_selA;
                r_addB      <= w_selB;
                r_issuedCnt <= r_issuedCnt + 1'b1;
            end
            if (r_tags[ADD_LAT].valid) begin
                r_rspValid <= w_rspOnehot;
                r_rspRes   <= add_res_i;
            end else begin
                r_rspValid <= '0;
            end
        end
    end

    assign add_a_o      = r_addA;
    assign add_b_o      = r_addB;
    assign rsp_valid_o  = r_rspValid;
    assign rsp_res_o    = r_rspRes;
    assign issued_cnt_o = r_issuedCnt;
    assign busy_o       = (r_state != IDLE) || w_inFlight;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with four requesters and a one-cycle
// registered adder modelled alongside it.
`timescale 1ns/1ps
module tb_adder_arbiter;

    logic        clk_i;
    logic        reset_i;
    logic        enable_i;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic [7:0]  add_a_o;
    logic [7:0]  add_b_o;
    logic [7:0]  add_res_i;
    logic [3:0]  rsp_valid_o;
    logic [7:0]  rsp_res_o;
    logic        busy_o;
    logic [31:0] issued_cnt_o;

    int testsRun  = 0;
    int failCount = 0;

    logic [7:0] fairSum [0:3];

    adder_arbiter #(
        .N_REQ   (4),
        .DATA_W  (8),
        .ADD_LAT (1),
        .CNT_W   (32)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .add_a_o      (add_a_o),
        .add_b_o      (add_b_o),
        .add_res_i    (add_res_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_res_o    (rsp_res_o),
        .busy_o       (busy_o),
        .issued_cnt_o (issued_cnt_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // The shared adder: one registered stage, wraps modulo 256.
    always @(posedge clk_i) begin
        add_res_i <= add_a_o + add_b_o;
    end

    // Safety net so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] valid);
        enable_i    = en;
        req_valid_i = valid;
    endtask

    task automatic setOps(input int r, input logic [7:0] a, input logic [7:0] b);
        req_a_i[r*8 +: 8] = a;
        req_b_i[r*8 +: 8] = b;
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic doReset();
        reset_i = 1'b1;
        applyStimulus(1'b0, 4'b0000);
        req_a_i = '0;
        req_b_i = '0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 64'(req_ready_o), 64'd0);
        checkOutput({tag, "_add_a"}, 64'(add_a_o), 64'd0);
        checkOutput({tag, "_add_b"}, 64'(add_b_o), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        checkOutput({tag, "_rsp_res"}, 64'(rsp_res_o), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
        checkOutput({tag, "_cnt"}, 64'(issued_cnt_o), 64'd0);
    endtask

    initial begin
        reset_i     = 1'b1;
        enable_i    = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;

        // ---- Reset state and single operation ----
        doReset();
        checkAllZero("reset");
        setOps(0, 8'd100, 8'd27);
        applyStimulus(1'b1, 4'b0001);
        #1 checkOutput("single_idle_ready", 64'(req_ready_o), 64'd0);
        tick();
        checkOutput("single_ready", 64'(req_ready_o), 64'b0001);
        tick();
        applyStimulus(1'b1, 4'b0000);
        checkOutput("single_add_a", 64'(add_a_o), 64'd100);
        checkOutput("single_add_b", 64'(add_b_o), 64'd27);
        checkOutput("single_cnt", 64'(issued_cnt_o), 64'd1);
        checkOutput("single_rsp_early0", 64'(rsp_valid_o), 64'd0);
        tick();
        checkOutput("single_rsp_early1", 64'(rsp_valid_o), 64'd0);
        tick();
        checkOutput("single_rsp_valid", 64'(rsp_valid_o), 64'b0001);
        checkOutput("single_rsp_res", 64'(rsp_res_o), 64'd127);
        tick();
        checkOutput("single_rsp_pulse", 64'(rsp_valid_o), 64'd0);
        checkOutput("single_rsp_hold", 64'(rsp_res_o), 64'd127);

        // ---- Result wraps modulo 256 ----
        setOps(2, 8'd200, 8'd100);
        applyStimulus(1'b1, 4'b0100);
        #1 checkOutput("wrap_ready", 64'(req_ready_o), 64'b0100);
        tick();
        applyStimulus(1'b1, 4'b0000);
        tick();
        tick();
        checkOutput("wrap_rsp_valid", 64'(rsp_valid_o), 64'b0100);
        checkOutput("wrap_rsp_res", 64'(rsp_res_o), 64'd44);

        // ---- Fairness: all four held valid for eight grants ----
        doReset();
        for (int i = 0; i < 4; i++) begin
            setOps(i, 8'(10*i + 1), 8'(i + 2));
        end
        fairSum[0] = 8'd3;
        fairSum[1] = 8'd14;
        fairSum[2] = 8'd25;
        fairSum[3] = 8'd36;
        applyStimulus(1'b1, 4'b1111);
        tick();
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc == 8) begin
                applyStimulus(1'b1, 4'b0000);
            end
            if (cyc < 8) begin
                checkOutput($sformatf("fair_grant%0d", cyc), 64'(req_ready_o),
                            64'(4'b0001 << (cyc % 4)));
            end
            if (cyc < 3) begin
                checkOutput($sformatf("fair_norsp%0d", cyc), 64'(rsp_valid_o), 64'd0);
            end else begin
                checkOutput($sformatf("fair_rsp_valid%0d", cyc - 3), 64'(rsp_valid_o),
                            64'(4'b0001 << ((cyc - 3) % 4)));
                checkOutput($sformatf("fair_rsp_res%0d", cyc - 3), 64'(rsp_res_o),
                            64'(fairSum[(cyc - 3) % 4]));
            end
            tick();
        end
        checkOutput("fair_cnt", 64'(issued_cnt_o), 64'd8);

        // ---- Pointer skip: pointer at 1, only req3 and req0 waiting ----
        doReset();
        setOps(0, 8'd1, 8'd1);
        applyStimulus(1'b1, 4'b0001);
        tick();
        checkOutput("skip_first_ready", 64'(req_ready_o), 64'b0001);
        tick();
        setOps(0, 8'd250, 8'd10);
        setOps(3, 8'd5, 8'd6);
        applyStimulus(1'b1, 4'b1001);
        #1 checkOutput("skip_grant3", 64'(req_ready_o), 64'b1000);
        tick();
        applyStimulus(1'b1, 4'b0001);
        #1 checkOutput("skip_grant0", 64'(req_ready_o), 64'b0001);
        tick();
        applyStimulus(1'b1, 4'b0000);
        checkOutput("skip_rsp_a_valid", 64'(rsp_valid_o), 64'b0001);
        checkOutput("skip_rsp_a_res", 64'(rsp_res_o), 64'd2);
        tick();
        checkOutput("skip_rsp_b_valid", 64'(rsp_valid_o), 64'b1000);
        checkOutput("skip_rsp_b_res", 64'(rsp_res_o), 64'd11);
        tick();
        checkOutput("skip_rsp_c_valid", 64'(rsp_valid_o), 64'b0001);
        checkOutput("skip_rsp_c_res", 64'(rsp_res_o), 64'd4);

        // ---- Drain: three back-to-back ops then enable drops ----
        setOps(1, 8'd1, 8'd2);
        setOps(2, 8'd3, 8'd4);
        setOps(3, 8'd128, 8'd128);
        applyStimulus(1'b1, 4'b1110);
        #1 checkOutput("drain_grant1", 64'(req_ready_o), 64'b0010);
        tick();
        applyStimulus(1'b1, 4'b1100);
        #1 checkOutput("drain_grant2", 64'(req_ready_o), 64'b0100);
        tick();
        applyStimulus(1'b1, 4'b1000);
        #1 checkOutput("drain_grant3", 64'(req_ready_o), 64'b1000);
        tick();
        applyStimulus(1'b0, 4'b0001);
        #1 checkOutput("drain_noready0", 64'(req_ready_o), 64'd0);
        checkOutput("drain_rsp1_valid", 64'(rsp_valid_o), 64'b0010);
        checkOutput("drain_rsp1_res", 64'(rsp_res_o), 64'd3);
        tick();
        checkOutput("drain_noready1", 64'(req_ready_o), 64'd0);
        checkOutput("drain_rsp2_valid", 64'(rsp_valid_o), 64'b0100);
        checkOutput("drain_rsp2_res", 64'(rsp_res_o), 64'd7);
        tick();
        checkOutput("drain_noready2", 64'(req_ready_o), 64'd0);
        checkOutput("drain_rsp3_valid", 64'(rsp_valid_o), 64'b1000);
        checkOutput("drain_rsp3_res", 64'(rsp_res_o), 64'd0);
        checkOutput("drain_busy_last", 64'(busy_o), 64'd1);
        tick();
        checkOutput("drain_rsp_done", 64'(rsp_valid_o), 64'd0);
        checkOutput("drain_busy_fall", 64'(busy_o), 64'd0);
        checkOutput("drain_noready3", 64'(req_ready_o), 64'd0);
        checkOutput("drain_cnt", 64'(issued_cnt_o), 64'd6);
        applyStimulus(1'b0, 4'b0000);

        // ---- Reset while two ops are in flight ----
        setOps(0, 8'd9, 8'd9);
        setOps(1, 8'd8, 8'd8);
        applyStimulus(1'b1, 4'b0011);
        tick();
        checkOutput("midrst_grant0", 64'(req_ready_o), 64'b0001);
        tick();
        applyStimulus(1'b1, 4'b0010);
        #1 checkOutput("midrst_grant1", 64'(req_ready_o), 64'b0010);
        tick();
        applyStimulus(1'b1, 4'b0000);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checkAllZero("midrst");
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("midrst_norsp%0d", k), 64'(rsp_valid_o), 64'd0);
        end
        applyStimulus(1'b1, 4'b1111);
        tick();
        checkOutput("midrst_next_grant", 64'(req_ready_o), 64'b0001);
        applyStimulus(1'b0, 4'b0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
